// File: rtl/split_data_array_arb_pkg.sv
// Shared types for the split data-array RW0 arbiter.
// The optional SPLIT_DATA_ARB_RR_EN macro is consumed by the top and by sda_arb_pick.
package sda_arb_pkg;

    // Controller states: sweeping the array with CLEAR_VALUE, or serving requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int NUM_REQ    = 2;

    // Geometry of the RAM macro this arbiter fronts.
    localparam int SDA_ADDR_W = 10;
    localparam int SDA_DATA_W = 8;

    // One unpacked requester slot.
    typedef struct packed {
        logic                  write;
        logic [SDA_ADDR_W-1:0] addr;
        logic [SDA_DATA_W-1:0] wdata;
        logic                  wmask;
    } req_t;

    // Index of the granted port for a one-hot 2-way grant vector.
    function automatic logic grant_idx(input logic [NUM_REQ-1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/split_data_array_arb_pick.sv
// 2-way grant selection for the RW0 port.
// Default build: fixed priority, port 0 over port 1.
// With SPLIT_DATA_ARB_RR_EN defined: on contention the port not granted last wins.
// Pure combinational function of the valid bits (and the last-grant pointer).
module sda_arb_pick
    import sda_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
`ifdef SPLIT_DATA_ARB_RR_EN
    input  logic               last,
`endif
    output logic [NUM_REQ-1:0] grant
);

    // One-hot grant, zero when nobody is asking.
    always_comb begin
        grant = '0;
        if (valid[0] && valid[1]) begin
`ifdef SPLIT_DATA_ARB_RR_EN
            grant = last ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end else if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/split_data_array_arb.sv
// Sole driver of the split data-array RW0 port. Port 0 is the refill/writeback
// engine, port 1 the core access pipe. Runs a full-array clear after reset
// (CLEAR_ON_RESET) or on clear_start, then arbitrates single-cycle accesses.
// Optional feature macro: SPLIT_DATA_ARB_RR_EN (round-robin instead of fixed priority).
//
// Handshake: a request on port p is accepted in the cycle where
// req_valid[p] && req_ready[p]; req_ready is combinational and at most one bit
// is set per cycle. An accepted read returns resp_valid[p] with resp_data
// exactly one cycle later; writes produce no response.
module split_data_array_arb
    import sda_arb_pkg::*;
#(
    parameter int                ADDR_W         = SDA_ADDR_W,
    parameter int                DATA_W         = SDA_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]    req_wmask,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_en,
    output logic                  ram_wmode,
    output logic                  ram_wmask,
    input  logic [DATA_W-1:0]     ram_rdata
);

    // The request struct is sized for the fixed macro geometry.
    if (ADDR_W != SDA_ADDR_W || DATA_W != SDA_DATA_W) begin : g_geometry_check
        $error("split_data_array_arb: ADDR_W/DATA_W must match sda_arb_pkg geometry");
    end

    // Last address of the sweep; the counter's extra MSB is never set before
    // this value is reached, so comparing the full width is equivalent.
    localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
    logic [NUM_REQ-1:0]  resp_q;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  accept;
    req_t                req_in [NUM_REQ];
    req_t                sel;

    // Unpack the flat request buses into per-port structs.
    always_comb begin
        for (int p = 0; p < NUM_REQ; p++) begin
            req_in[p].write = req_write[p];
            req_in[p].addr  = req_addr[p*ADDR_W +: ADDR_W];
            req_in[p].wdata = req_wdata[p*DATA_W +: DATA_W];
            req_in[p].wmask = req_wmask[p];
        end
    end

`ifdef SPLIT_DATA_ARB_RR_EN
    logic rr_last_q;

    // Last-granted port; starts at 1 so port 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_last_q <= 1'b1;
        end else if (|accept) begin
            rr_last_q <= accept[1];
        end
    end

    sda_arb_pick u_pick (
        .valid (req_valid),
        .last  (rr_last_q),
        .grant (grant)
    );
`else
    sda_arb_pick u_pick (
        .valid (req_valid),
        .grant (grant)
    );
`endif

    // State register, clear counter and the one-cycle read response tag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            resp_q    <= accept & ~req_write;
        end
    end

    // Next state, grant qualification and RAM port mux.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        accept     = '0;
        sel        = '0;
        ram_en     = 1'b0;
        ram_wmode  = 1'b0;
        ram_wmask  = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        clear_busy = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                clear_busy = 1'b1;
                ram_en     = 1'b1;
                ram_wmode  = 1'b1;
                ram_wmask  = 1'b1;
                ram_addr   = clr_cnt_q[ADDR_W-1:0];
                ram_wdata  = CLEAR_VALUE;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_start) begin
                    // Clear takes the cycle; no request is granted alongside it.
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (|grant) begin
                    accept    = grant;
                    sel       = req_in[grant_idx(grant)];
                    ram_en    = 1'b1;
                    ram_wmode = sel.write;
                    ram_wmask = sel.write & sel.wmask;
                    ram_addr  = sel.addr;
                    ram_wdata = sel.wdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold the RAM and requesters quiet while reset is asserted.
        if (!reset_n) begin
            accept     = '0;
            ram_en     = 1'b0;
            ram_wmode  = 1'b0;
            ram_wmask  = 1'b0;
            ram_addr   = '0;
            ram_wdata  = '0;
            clear_busy = CLEAR_ON_RESET;
        end
    end

    // Grants and the shared response bus (zero when no response is due).
    always_comb begin
        req_ready  = accept;
        resp_valid = resp_q;
        resp_data  = (|resp_q) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_split_data_array_arb.sv
// Self-checking bench for split_data_array_arb: behavioural RAM, response
// scoreboard, and one task per scenario.
module tb_split_data_array_arb;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;

    logic                clock;
    logic                reset_n;
    logic                clear_start;
    logic                clear_busy;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_wmask;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_en;
    logic                ram_wmode;
    logic                ram_wmask;
    logic [DATA_W-1:0]   ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [1:0]        exp_port_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] mem   [DEPTH];

    split_data_array_arb dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_en      (ram_en),
        .ram_wmode   (ram_wmode),
        .ram_wmask   (ram_wmask),
        .ram_rdata   (ram_rdata)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Behavioural RW0 macro: 1-cycle synchronous read, masked write
    initial ram_rdata = '0;
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_wmode) begin
                if (ram_wmask) mem[ram_addr] <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // Scoreboard: every response must match the oldest expected read
    always @(negedge clock) begin
        logic [DATA_W-1:0] e;
        logic [1:0]        ep;
        if (reset_n && resp_valid !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got resp_valid=%b data=%h, required no response", resp_valid, resp_data);
            end else begin
                e  = exp_q.pop_front();
                ep = exp_port_q.pop_front();
                if (resp_valid !== ep || resp_data !== e) begin
                    errors++;
                    $display("FAIL resp_data: got valid=%b data=%h, required valid=%b data=%h", resp_valid, resp_data, ep, e);
                end
            end
        end
    end

    // Driver helpers
    task automatic set_req(input int p, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic m);
        req_valid[p]                = 1'b1;
        req_write[p]                = w;
        req_addr[p*ADDR_W +: ADDR_W] = a;
        req_wdata[p*DATA_W +: DATA_W] = d;
        req_wmask[p]                = m;
    endtask

    task automatic expect_read(input int p, input logic [ADDR_W-1:0] a);
        exp_q.push_back(model[a]);
        exp_port_q.push_back(p == 0 ? 2'b01 : 2'b10);
    endtask

    // Checks n consecutive clear cycles starting at address 0, with both
    // requesters asking and optionally clear_start pulsing mid-sweep.
    task automatic clear_sweep(input int n, input bit noise);
        req_valid = 2'b00;
        set_req(0, 1'b0, 10'h020, 8'h00, 1'b0);
        set_req(1, 1'b0, 10'h021, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (noise) clear_start = (i >= 100 && i < 200);
            checks++;
            if ({ram_en, ram_wmode, ram_wmask} !== 3'b111 || ram_addr !== ADDR_W'(i) ||
                ram_wdata !== 8'h00 || req_ready !== 2'b00 || clear_busy !== 1'b1) begin
                errors++;
                $display("FAIL clear_sweep i=%0d: got en/wm/mk=%b addr=%h wdata=%h ready=%b busy=%b, required 111 addr=%h wdata=00 ready=00 busy=1",
                         i, {ram_en, ram_wmode, ram_wmask}, ram_addr, ram_wdata, req_ready, clear_busy, ADDR_W'(i));
            end
        end
        req_valid   = 2'b00;
        clear_start = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
        @(negedge clock);
        checks++;
        if (clear_busy !== 1'b0 || ram_en !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL clear_done: got busy=%b ram_en=%b ready=%b, required busy=0 ram_en=0 ready=00", clear_busy, ram_en, req_ready);
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        clear_start = 1'b0;
        req_valid   = 2'b11;
        req_write   = 2'b00;
        req_addr    = '0;
        req_wdata   = '0;
        req_wmask   = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || ram_en !== 1'b0 || ram_wmode !== 1'b0 ||
            ram_wmask !== 1'b0 || clear_busy !== 1'b1 || resp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: got ready=%b resp=%b en=%b wm=%b mk=%b busy=%b data=%h, required 00 00 0 0 0 1 00",
                     req_ready, resp_valid, ram_en, ram_wmode, ram_wmask, clear_busy, resp_data);
        end
        @(posedge clock) #1;
        reset_n = 1'b1;
        clear_sweep(DEPTH, 1'b0);
    endtask

    task automatic test_write_read();
        @(posedge clock) #1;
        req_valid = 2'b00;
        set_req(1, 1'b1, 10'h3FF, 8'hA5, 1'b1);
        model[10'h3FF] = 8'hA5;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10 || ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_wmask !== 1'b1 ||
            ram_addr !== 10'h3FF || ram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_drive: got ready=%b en=%b wm=%b mk=%b addr=%h wdata=%h, required 10 1 1 1 3ff a5",
                     req_ready, ram_en, ram_wmode, ram_wmask, ram_addr, ram_wdata);
        end
        @(posedge clock) #1;
        set_req(1, 1'b0, 10'h3FF, 8'h00, 1'b0);
        expect_read(1, 10'h3FF);
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10 || ram_en !== 1'b1 || ram_wmode !== 1'b0 || ram_wmask !== 1'b0 || ram_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL rd_drive: got ready=%b en=%b wm=%b mk=%b addr=%h, required 10 1 0 0 3ff",
                     req_ready, ram_en, ram_wmode, ram_wmask, ram_addr);
        end
        @(posedge clock) #1;
        req_valid = 2'b00;
        @(negedge clock);
        checks++;
        if (resp_valid !== 2'b10) begin
            errors++;
            $display("FAIL rd_latency: got resp_valid=%b, required 10", resp_valid);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] g;
        @(posedge clock) #1;
        set_req(1, 1'b1, 10'h020, 8'h11, 1'b1);
        model[10'h020] = 8'h11;
        @(posedge clock) #1;
        set_req(1, 1'b1, 10'h021, 8'h22, 1'b1);
        model[10'h021] = 8'h22;
        @(posedge clock) #1;
        set_req(0, 1'b0, 10'h020, 8'h00, 1'b0);
        set_req(1, 1'b0, 10'h021, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
`ifdef SPLIT_DATA_ARB_RR_EN
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            g = 2'b01;
`endif
            checks++;
            if (req_ready !== g) begin
                errors++;
                $display("FAIL arb_grant i=%0d: got ready=%b, required %b", i, req_ready, g);
            end
            if (g == 2'b01) expect_read(0, 10'h020);
            else            expect_read(1, 10'h021);
            @(posedge clock) #1;
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_read_then_clear();
        @(posedge clock) #1;
        set_req(0, 1'b0, 10'h020, 8'h00, 1'b0);
        expect_read(0, 10'h020);
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rc_accept: got ready=%b, required 01", req_ready);
        end
        @(posedge clock) #1;
        req_valid   = 2'b00;
        clear_start = 1'b1;
        set_req(1, 1'b0, 10'h021, 8'h00, 1'b0);
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b01 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL rc_clear_wins: got ready=%b resp=%b en=%b, required 00 01 0", req_ready, resp_valid, ram_en);
        end
        @(posedge clock) #1;
        clear_start = 1'b0;
        req_valid   = 2'b00;
        clear_sweep(DEPTH, 1'b1);
    endtask

    task automatic test_reset_mid_clear();
        @(posedge clock) #1;
        clear_start = 1'b1;
        @(posedge clock) #1;
        clear_start = 1'b0;
        req_valid   = 2'b00;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            checks++;
            if (ram_en !== 1'b1 || ram_addr !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL mid_clear i=%0d: got en=%b addr=%h, required 1 %h", i, ram_en, ram_addr, ADDR_W'(i));
            end
        end
        @(posedge clock) #1;
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || ram_en !== 1'b0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b resp=%b en=%b busy=%b, required 00 00 0 1", req_ready, resp_valid, ram_en, clear_busy);
        end
        @(posedge clock) #1;
        reset_n = 1'b1;
        clear_sweep(DEPTH, 1'b0);
    endtask

    task automatic test_wmask();
        @(posedge clock) #1;
        req_valid = 2'b00;
        set_req(0, 1'b1, 10'h010, 8'h5A, 1'b1);
        model[10'h010] = 8'h5A;
        @(posedge clock) #1;
        set_req(0, 1'b1, 10'h010, 8'hFF, 1'b0);
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b01 || ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_wmask !== 1'b0) begin
            errors++;
            $display("FAIL wmask_drive: got ready=%b en=%b wm=%b mk=%b, required 01 1 1 0", req_ready, ram_en, ram_wmode, ram_wmask);
        end
        @(posedge clock) #1;
        req_valid = 2'b00;
        set_req(1, 1'b0, 10'h010, 8'h00, 1'b0);
        expect_read(1, 10'h010);
        @(posedge clock) #1;
        req_valid = 2'b00;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [4];
        addrs[0] = 10'h030; addrs[1] = 10'h031; addrs[2] = 10'h010; addrs[3] = 10'h030;
        @(posedge clock) #1;
        set_req(0, 1'b1, 10'h030, 8'h33, 1'b1);
        model[10'h030] = 8'h33;
        @(posedge clock) #1;
        set_req(0, 1'b1, 10'h031, 8'(8'h40 + $urandom_range(0, 15)), 1'b1);
        model[10'h031] = req_wdata[7:0];
        @(posedge clock) #1;
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1'b0, addrs[i], 8'h00, 1'b0);
            expect_read(1, addrs[i]);
            @(negedge clock);
            checks++;
            if (req_ready !== 2'b10 || ram_addr !== addrs[i]) begin
                errors++;
                $display("FAIL b2b_accept i=%0d: got ready=%b addr=%h, required 10 %h", i, req_ready, ram_addr, addrs[i]);
            end
            @(posedge clock) #1;
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_read_then_clear();
        test_reset_mid_clear();
        test_wmask();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding reads, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
